// File: rtl/tictactoe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tictactoe_pkg
// Description : Shared types, board constants and helpers for the
//               tic-tac-toe design (input encoder, game FSM, VGA path).
// Contents    : sel_state_t  - move-select handshake states
//               BOARD_DIM    - cells per row/column
//               BOARD_CELLS  - total cells on the board
//               idx_to_onehot- cell index (0..8) to 9-bit one-hot
// Revision    : 1.0 - initial release
// ============================================================================
package tictactoe_pkg;

  typedef enum logic {
    SEL_IDLE    = 1'b0,
    SEL_PENDING = 1'b1
  } sel_state_t;

  localparam int BOARD_DIM   = 3;
  localparam int BOARD_CELLS = 9;

  // Out-of-range indices map to an all-zero word rather than wrapping,
  // so a corrupted index can never light a wrong cell.
  function automatic logic [8:0] idx_to_onehot(input logic [3:0] idx);
    logic [8:0] onehot;
    onehot = '0;
    if (idx < 4'd9) begin
      onehot = 9'd1 << idx;
    end
    return onehot;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchronizer, counter-based debouncer and
//               registered one-cycle press pulse for one active-low button.
// Ports       : clk    in  1  system clock
//               rst    in  1  synchronous active-high reset
//               btn_n  in  1  raw active-low button (asynchronous)
//               press  out 1  one-cycle pulse on each debounced press
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q,     sync1_d;
  logic             sync2_q,     sync2_d;
  logic             level_q,     level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             press_q,     press_d;

  always_comb begin
    sync1_d     = btn_n;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    // Count only while the synced level disagrees; any agreement restarts
    // the hold period, which is what rejects bounce.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Edge detect against the previous debounced level so the pulse is a
    // clean registered output one cycle after the level changes.
    level_dly_d = level_q;
    press_d     = level_dly_q & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/move_input_encoder.sv
`default_nettype none
// ============================================================================
// Module      : move_input_encoder
// Description : Player-input front end. Debounces right/down/select buttons,
//               tracks a 3x3 cursor and presents confirmed moves to the game
//               FSM through a valid/ack handshake.
// Ports       : MAX10_CLK1_50 in  1  system clock
//               rst           in  1  synchronous active-high reset
//               btn_right_n   in  1  raw right button, active-low
//               btn_down_n    in  1  raw down button, active-low
//               btn_select_n  in  1  raw select button, active-low
//               enable        in  1  game FSM accepts moves
//               move_ack      in  1  game FSM consumed the move (pulse)
//               cursor        out 4  cursor cell index row*3+col
//               cursor_onehot out 9  one-hot of cursor
//               move          out 9  one-hot of latched move, 0 if not valid
//               move_valid    out 1  move presented, held until ack/abort
// Revision    : 1.0 - initial release
// ============================================================================
module move_input_encoder
  import tictactoe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic       btn_right_n,
  input  logic       btn_down_n,
  input  logic       btn_select_n,
  input  logic       enable,
  input  logic       move_ack,
  output logic [3:0] cursor,
  output logic [8:0] cursor_onehot,
  output logic [8:0] move,
  output logic       move_valid
);

  logic press_right;
  logic press_down;
  logic press_select;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk   (MAX10_CLK1_50),
    .rst   (rst),
    .btn_n (btn_right_n),
    .press (press_right)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (MAX10_CLK1_50),
    .rst   (rst),
    .btn_n (btn_down_n),
    .press (press_down)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_select (
    .clk   (MAX10_CLK1_50),
    .rst   (rst),
    .btn_n (btn_select_n),
    .press (press_select)
  );

  localparam logic [1:0] LAST_POS = 2'(BOARD_DIM - 1);

  logic [1:0] row_q,           row_d;
  logic [1:0] col_q,           col_d;
  logic [3:0] cursor_q,        cursor_d;
  logic [8:0] cursor_onehot_q, cursor_onehot_d;
  logic [8:0] move_q,          move_d;
  logic       move_valid_q,    move_valid_d;
  sel_state_t state_q,         state_d;

  // Cursor: independent of the select FSM and of enable. The index and
  // one-hot are derived from the next row/col so they change together
  // with row/col on the same edge.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (press_right) begin
      col_d = (col_q == LAST_POS) ? 2'd0 : col_q + 2'd1;
    end
    if (press_down) begin
      row_d = (row_q == LAST_POS) ? 2'd0 : row_q + 2'd1;
    end
    cursor_d        = ({2'b00, row_d} * 4'd3) + {2'b00, col_d};
    cursor_onehot_d = idx_to_onehot(cursor_d);
  end

  // Select handshake. The captured move is the registered one-hot, i.e.
  // the cursor as displayed before any same-cycle cursor step.
  always_comb begin
    state_d      = state_q;
    move_d       = move_q;
    move_valid_d = move_valid_q;
    case (state_q)
      SEL_IDLE: begin
        if (press_select && enable) begin
          move_d       = cursor_onehot_q;
          move_valid_d = 1'b1;
          state_d      = SEL_PENDING;
        end
      end
      SEL_PENDING: begin
        // Ack and abort share one clearing path, so both together have
        // the same single effect as either alone.
        if (move_ack || !enable) begin
          move_d       = '0;
          move_valid_d = 1'b0;
          state_d      = SEL_IDLE;
        end
      end
      default: begin
        move_d       = '0;
        move_valid_d = 1'b0;
        state_d      = SEL_IDLE;
      end
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      row_q           <= 2'd0;
      col_q           <= 2'd0;
      cursor_q        <= 4'd0;
      cursor_onehot_q <= 9'h001;
      move_q          <= '0;
      move_valid_q    <= 1'b0;
      state_q         <= SEL_IDLE;
    end else begin
      row_q           <= row_d;
      col_q           <= col_d;
      cursor_q        <= cursor_d;
      cursor_onehot_q <= cursor_onehot_d;
      move_q          <= move_d;
      move_valid_q    <= move_valid_d;
      state_q         <= state_d;
    end
  end

  assign cursor        = cursor_q;
  assign cursor_onehot = cursor_onehot_q;
  assign move          = move_q;
  assign move_valid    = move_valid_q;

endmodule
`default_nettype wire

// File: doc/move_input_encoder.md
Name: move_input_encoder

Overview:
- Front end for the tic-tac-toe game FSM, on the player-input side of the board/move interface.
- Turns three raw active-low push buttons (right, down, select) into a 3x3 cursor position and a one-hot move word.
- Hands each confirmed move to the game FSM with a valid/ack handshake.
- Also drives the continuous cursor one-hot that the VGA path uses for cell highlighting.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized button level must hold before the debounced level changes (10 ms at 50 MHz; use 4 in simulation).

Ports:
MAX10_CLK1_50  in   1  system clock; the only clock.
rst            in   1  reset, synchronous, active-high.
btn_right_n    in   1  raw button, active-low, asynchronous to clock.
btn_down_n     in   1  raw button, active-low, asynchronous to clock.
btn_select_n   in   1  raw button, active-low, asynchronous to clock.
enable         in   1  game FSM is in its play state and accepts moves.
move_ack       in   1  game FSM has consumed the presented move; one-cycle pulse.
cursor         out  4  cursor cell index, 0..8, equal to row*3+col.
cursor_onehot  out  9  one-hot of cursor; bit i set for cell i.
move           out  9  one-hot of the latched move; 0 when move_valid=0.
move_valid     out  1  move is presented and held stable until ack or abort.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - row=0, col=0, cursor=0, cursor_onehot=9'h001.
  - move=0, move_valid=0, FSM=SEL_IDLE.
  - Synchronizer flops and debounced levels = 1 (released); debounce counters = 0.
  - Reset has priority over every other event, including reset while SEL_PENDING.
- Per button:
  - 2-flop synchronizer.
  - Counter increments while the synced level differs from the debounced level and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level takes the synced level and the counter clears.
  - A registered press pulse fires for exactly 1 cycle on each debounced 1->0 transition. Release produces no event.
- Latency:
  - Counting the first edge that samples the raw button low as edge 1, press pulse is high after edge DEBOUNCE_CYCLES+3.
  - The registered effect (cursor update or move_valid) is visible after edge DEBOUNCE_CYCLES+4.
- Cursor:
  - Right press: col <= (col==2) ? 0 : col+1.
  - Down press: row <= (row==2) ? 0 : row+1.
  - Simultaneous right and down pulses apply both in the same cycle.
  - Cursor moves in every FSM state, with or without enable.
  - cursor and cursor_onehot are registered from row/col in the same cycle.
- Select FSM:
  - SEL_IDLE:
    - select press with enable=1: move <= cursor_onehot (value before any same-cycle cursor update), move_valid <= 1, go to SEL_PENDING.
    - select press with enable=0 is discarded.
    - move_ack is ignored.
  - SEL_PENDING:
    - move and move_valid are held unchanged; further select presses are discarded.
    - move_ack=1: move_valid <= 0, move <= 0, go to SEL_IDLE; a new select is accepted from the following cycle.
    - enable=0 (abort, e.g. game reset or win): same clearing as ack, go to SEL_IDLE.
    - ack and enable=0 in the same cycle: single clear, no double effect.
- Invariants:
  - move is never nonzero while move_valid=0.
  - move is exactly one-hot while move_valid=1.
  - cursor is never 9..15.
- Occupancy: the block does not check cell occupancy; the game FSM validates the move.

Decomposition:
- Package tictactoe_pkg:
  - typedef enum logic {SEL_IDLE, SEL_PENDING} sel_state_t.
  - localparams BOARD_DIM=3, BOARD_CELLS=9.
  - Function idx_to_onehot(logic [3:0]) returning logic [8:0].
  - Shared with the game FSM and VGA controller.
- Sub-module button_debouncer (sync + debounce + press pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: hold rst 3 cycles, then release with buttons high -> cursor=0, cursor_onehot=9'h001, move=0, move_valid=0.
2. Right pressed 4 times (low 10 cycles, high 10 cycles each) -> cursor 1,2,0,1; final cursor_onehot=9'h002. First update appears exactly after edge 8 of the first press.
3. Bounce: btn_right_n pattern low 2 / high 1 / low 3 / high -> no press pulse, cursor unchanged at 0.
4. Down x2, right x1, then select with enable=1 -> cursor=7, move_valid=1, move=9'h080. Pulse move_ack for 1 cycle -> next cycle move_valid=0, move=0.
5. While SEL_PENDING with move=9'h080: press right -> cursor=8 but move stays 9'h080; second select ignored. Drop enable -> next cycle move_valid=0, move=0, FSM=SEL_IDLE.
6. Select with enable=0 -> move_valid stays 0. Then enable=1, select -> move_valid=1. Assert rst mid-pending -> next cycle all reset values, including cursor=0.
